// File: rtl/wb_nor_flash_pkg.sv
// -----------------------------------------------------------------------------
// wb_nor_flash_pkg
// Shared types for the Wishbone-to-asynchronous-NOR-flash read bridge:
// controller state encoding and the Wishbone B3 cycle-type (CTI) and
// burst-type (BTE) encodings.
// -----------------------------------------------------------------------------
package wb_nor_flash_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        ACK  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_nor_flash_burst_adr.sv
// -----------------------------------------------------------------------------
// wb_burst_adr
// Next Wishbone byte address of an incrementing burst. The address advances by
// one WB word; for wrapping bursts only the bits inside the 4/8/16-beat block
// take the incremented value, the block base is kept.
// Ports:
//   adr      in  WB_AW  current byte address
//   bte      in  2      burst type extension
//   next_adr out WB_AW  address of the following beat
// -----------------------------------------------------------------------------
module wb_burst_adr
    import wb_nor_flash_pkg::*;
#(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
) (
    input  logic [WB_AW-1:0] adr,
    input  logic [1:0]       bte,
    output logic [WB_AW-1:0] next_adr
);

    localparam int WB_BYTES = WB_DW / 8;
    localparam logic [WB_AW-1:0] MASK4  = WB_AW'(WB_BYTES * 4 - 1);
    localparam logic [WB_AW-1:0] MASK8  = WB_AW'(WB_BYTES * 8 - 1);
    localparam logic [WB_AW-1:0] MASK16 = WB_AW'(WB_BYTES * 16 - 1);

    logic [WB_AW-1:0] inc;

    always_comb begin
        inc      = adr + WB_AW'(WB_BYTES);
        next_adr = inc;
        case (bte)
            BTE_WRAP4:  next_adr = (adr & ~MASK4)  | (inc & MASK4);
            BTE_WRAP8:  next_adr = (adr & ~MASK8)  | (inc & MASK8);
            BTE_WRAP16: next_adr = (adr & ~MASK16) | (inc & MASK16);
            default:    next_adr = inc;
        endcase
    end

endmodule

// File: rtl/wb_nor_flash.sv
// -----------------------------------------------------------------------------
// wb_nor_flash
// Read-only Wishbone B3 slave in front of an asynchronous (optionally page
// mode) parallel NOR flash. Each WB word is assembled from WB_DW/FLASH_DW flash
// beats, first beat in the MSBs. Writes are answered with wb_err_o.
// Build option: define WB_NOR_PAGE_EN to let beats that stay in the same
// PAGE_WORDS-aligned page skip the address phase and wait only PAGE_LAT.
// Ports:
//   wb_clk_i, wb_rstn_i          clock, async active-low reset
//   wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i   WB slave inputs
//   wb_ack_o, wb_err_o, wb_dat_o WB slave outputs
//   flash_dat_i                  flash read data
//   flash_adr_o, flash_csn_o, flash_oen_o, flash_wen_o,
//   flash_advn_o, flash_clk_o, flash_rstn_o   flash control
// -----------------------------------------------------------------------------
module wb_nor_flash
    import wb_nor_flash_pkg::*;
#(
    parameter int FLASH_SIZE = 67108864,
    parameter int FLASH_DW   = 16,
    parameter int FLASH_AW   = $clog2(FLASH_SIZE / (FLASH_DW / 8)),
    parameter int WB_DW      = 32,
    parameter int WB_AW      = 32,
    parameter int RD_LAT     = 16,
    parameter int PAGE_LAT   = 4,
    parameter int PAGE_WORDS = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic [WB_AW-1:0]    wb_adr_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    input  logic [WB_DW/8-1:0]  wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic [2:0]          wb_cti_i,
    input  logic [1:0]          wb_bte_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [WB_DW-1:0]    wb_dat_o,
    input  logic [FLASH_DW-1:0] flash_dat_i,
    output logic [FLASH_AW-1:0] flash_adr_o,
    output logic                flash_csn_o,
    output logic                flash_oen_o,
    output logic                flash_wen_o,
    output logic                flash_advn_o,
    output logic                flash_clk_o,
    output logic                flash_rstn_o
);

    localparam int FSH    = $clog2(FLASH_DW / 8);
    localparam int BEATS  = WB_DW / FLASH_DW;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PG_SH  = $clog2(PAGE_WORDS);
`ifdef WB_NOR_PAGE_EN
    localparam bit PAGE_MODE = 1'b1;
`else
    localparam bit PAGE_MODE = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [WB_AW-1:0]    wb_adr_q, burst_adr;
    logic [FLASH_AW-1:0] last_adr, flash_adr_inc, burst_fadr;
    logic [7:0]          cnt_q;
    logic [BEAT_W-1:0]   beat_q, lane;
    logic                start, wait_done, last_beat;
    logic                page_hit_word, page_hit_burst, burst_go, busy_d;
    logic                unused_ok;

    assign flash_wen_o  = 1'b1;
    assign flash_clk_o  = 1'b0;
    assign flash_rstn_o = wb_rstn_i;
    assign unused_ok    = ^{wb_dat_i, wb_sel_i};

    assign start         = wb_cyc_i & wb_stb_i;
    assign wait_done     = (cnt_q == 8'd1);
    assign last_beat     = (beat_q == BEAT_W'(BEATS - 1));
    // Big-endian packing: beat 0 lands in the top lane.
    assign lane          = BEAT_W'(BEATS - 1) - beat_q;
    assign flash_adr_inc = flash_adr_o + FLASH_AW'(1);
    assign burst_fadr    = burst_adr[FSH +: FLASH_AW];
    assign burst_go      = start && (wb_cti_i == CTI_INCR);
    // Same-page tests: next word of this WB word vs. current word, and first
    // word of the next burst beat vs. the last word actually read.
    assign page_hit_word  = PAGE_MODE &&
        (flash_adr_inc[FLASH_AW-1:PG_SH] == flash_adr_o[FLASH_AW-1:PG_SH]);
    assign page_hit_burst = PAGE_MODE &&
        (burst_fadr[FLASH_AW-1:PG_SH] == last_adr[FLASH_AW-1:PG_SH]);
    assign busy_d = (state_d == ADDR) || (state_d == WAIT) || (state_d == ACK);

    wb_burst_adr #(.WB_AW(WB_AW), .WB_DW(WB_DW)) u_burst_adr (
        .adr      (wb_adr_q),
        .bte      (wb_bte_i),
        .next_adr (burst_adr)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = wb_we_i ? ERR : ADDR;
            ADDR: state_d = wb_cyc_i ? WAIT : IDLE;
            WAIT: begin
                if (!wb_cyc_i)          state_d = IDLE;
                else if (wait_done) begin
                    if (last_beat)          state_d = ACK;
                    else if (page_hit_word) state_d = WAIT;
                    else                    state_d = ADDR;
                end
            end
            ACK: begin
                if (burst_go) state_d = page_hit_burst ? WAIT : ADDR;
                else          state_d = IDLE;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free and
    // line up with the state they describe.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            flash_adr_o  <= '0;
            flash_csn_o  <= 1'b1;
            flash_oen_o  <= 1'b1;
            flash_advn_o <= 1'b1;
            wb_adr_q     <= '0;
            last_adr     <= '0;
            cnt_q        <= 8'd0;
            beat_q       <= '0;
        end else begin
            wb_ack_o     <= (state_d == ACK);
            wb_err_o     <= (state_d == ERR);
            flash_advn_o <= (state_d != ADDR);
            flash_csn_o  <= !busy_d;
            flash_oen_o  <= !busy_d;
            case (state_q)
                IDLE: begin
                    if (start && !wb_we_i) begin
                        wb_adr_q    <= wb_adr_i;
                        flash_adr_o <= wb_adr_i[FSH +: FLASH_AW];
                        beat_q      <= '0;
                    end
                end
                ADDR: cnt_q <= (state_d == WAIT) ? 8'(RD_LAT) : 8'd0;
                WAIT: begin
                    if (!wb_cyc_i) begin
                        cnt_q <= 8'd0;
                    end else if (wait_done) begin
                        wb_dat_o[lane*FLASH_DW +: FLASH_DW] <= flash_dat_i;
                        last_adr    <= flash_adr_o;
                        flash_adr_o <= flash_adr_inc;
                        beat_q      <= beat_q + BEAT_W'(1);
                        cnt_q       <= (state_d == WAIT) ? 8'(PAGE_LAT) : 8'd0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ACK: begin
                    if (state_d != IDLE) begin
                        wb_adr_q    <= burst_adr;
                        flash_adr_o <= burst_fadr;
                        beat_q      <= '0;
                        cnt_q       <= (state_d == WAIT) ? 8'(PAGE_LAT) : 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wb_nor_flash.md
WB_NOR_FLASH -- requirements
Module: wb_nor_flash

Interface
REQ-001 SHALL have parameter FLASH_SIZE, default 67108864, flash capacity in bytes.
REQ-002 SHALL have parameter FLASH_DW, default 16, flash data width in bits; legal values 8 and 16.
REQ-003 SHALL have parameter FLASH_AW, default $clog2(FLASH_SIZE/(FLASH_DW/8)), flash word-address width.
REQ-004 SHALL have parameter WB_DW, default 32, Wishbone data width; SHALL be an integer multiple of FLASH_DW.
REQ-005 SHALL have parameter WB_AW, default 32, Wishbone byte-address width.
REQ-006 SHALL have parameter RD_LAT, default 16, random-access wait in cycles; range 1..255.
REQ-007 SHALL have parameter PAGE_LAT, default 4, in-page wait in cycles; range 1..RD_LAT.
REQ-008 SHALL have parameter PAGE_WORDS, default 16, flash page size in flash words; power of two.
REQ-009 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-010 wb_rstn_i  in  1  reset; asynchronous assert, active-low.
REQ-011 wb_adr_i  in  WB_AW  byte address; wb_dat_i  in  WB_DW  unused (writes rejected); wb_sel_i  in  WB_DW/8  ignored for reads.
REQ-012 wb_we_i, wb_cyc_i, wb_stb_i  in  1 each; wb_cti_i  in  3; wb_bte_i  in  2  (classic Wishbone B3 meaning).
REQ-013 wb_ack_o, wb_err_o  out  1 each; wb_dat_o  out  WB_DW  read data.
REQ-014 flash_dat_i  in  FLASH_DW; flash_adr_o  out  FLASH_AW; flash_csn_o, flash_oen_o, flash_wen_o, flash_advn_o, flash_clk_o, flash_rstn_o  out  1 each.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, WAIT, ACK, ERR.
REQ-016 IDLE: cyc&stb&~we -> ADDR, latching flash_adr_o = wb_adr_i[log2(FLASH_DW/8) +: FLASH_AW]; cyc&stb&we -> ERR.
REQ-017 ADDR: one cycle, flash_advn_o=0, wait counter loaded with RD_LAT -> WAIT.
REQ-018 WAIT: counter decrements each cycle; on its last cycle flash_dat_i SHALL be captured into the current WB lane, and flash_adr_o incremented.
REQ-019 Beats per WB word N=WB_DW/FLASH_DW; the first captured flash word SHALL occupy the MSBs of wb_dat_o (big-endian); after a non-final beat, next state SHALL be ADDR (or WAIT with PAGE_LAT, see REQ-029).
REQ-020 After the final beat -> ACK; wb_ack_o SHALL be registered, high exactly one cycle, with wb_dat_o stable while high.
REQ-021 Single read latency: wb_ack_o high in cycle N*(RD_LAT+1)+1, counting the cycle where stb is first sampled as cycle 0.
REQ-022 In ACK with cti=010 and cyc&stb held: next WB address = current + WB_DW/8, wrapped per bte (00 linear, 01/10/11 wrap at 4/8/16 beats) -> ADDR; otherwise -> IDLE.
REQ-023 ERR: wb_err_o high one cycle (cycle 1), no flash activity, -> IDLE.
REQ-024 cyc deasserted in ADDR/WAIT: SHALL abort to IDLE next cycle, no ack, data discarded.
REQ-025 flash_csn_o and flash_oen_o SHALL be low only in ADDR/WAIT/ACK; flash_wen_o=1, flash_clk_o=0 constantly; flash_rstn_o=wb_rstn_i combinationally.
REQ-026 wb_adr_i bits above flash range SHALL be ignored (aliasing); flash_adr_o SHALL wrap modulo 2^FLASH_AW.

Reset
REQ-027 On wb_rstn_i low, immediately: state IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, flash_adr_o=0, flash_csn_o=1, flash_oen_o=1, flash_advn_o=1, counters 0.
REQ-028 Reset mid-transaction SHALL drop the access with no ack/err; first post-reset request starts from IDLE.

Configuration
REQ-029 WB_NOR_PAGE_EN defined: a beat whose flash address stays within the same PAGE_WORDS-aligned page as the previous beat (within one word or a continuing burst) SHALL skip ADDR and wait PAGE_LAT cycles; page-crossing beats use ADDR+RD_LAT.
REQ-030 WB_NOR_PAGE_EN undefined: every beat SHALL use ADDR+RD_LAT; PAGE_LAT and PAGE_WORDS unused.

Structure
REQ-031 Package wb_nor_flash_pkg SHALL hold the state enum and CTI/BTE encodings (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111, BTE_LINEAR/WRAP4/WRAP8/WRAP16).
REQ-032 Sub-module wb_burst_adr SHALL compute the next burst address from address, bte and WB_DW.

Verification
REQ-033 Single read 0x100, defaults, flash words 0xAAAA@0x80, 0x5555@0x81 -> wb_dat_o=0xAAAA5555, ack in cycle 35 only.
REQ-034 Write at 0x0 -> wb_err_o in cycle 1, flash_csn_o stays 1, no ack.
REQ-035 4-beat cti=010 bte=01 burst from 0x08 -> addresses 0x08,0x0C,0x00,0x04, four single-cycle acks.
REQ-036 With WB_NOR_PAGE_EN, single read 0x100 -> ack in cycle 22 (1+17+4); second beat has no flash_advn_o pulse.
REQ-037 wb_rstn_i low in WAIT cycle 10 -> all outputs at reset values same cycle, no ack; next read completes normally.
REQ-038 cyc dropped in WAIT cycle 5 -> IDLE next cycle, flash_csn_o=1, no ack.
